// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and single-outstanding instruction fetch sequencer
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   imemReqValid/Addr/Ready       fetch request to instruction memory (addr == pc)
//   imemRespValid/Data            fetch response, at most one outstanding
//   instValid/Data/Pc, instReady  one-entry decode buffer toward decode
//   jump, jumpReg, assertBranch   redirect requests from execute
//   branchPc, rs1Val, signExtImm  redirect target operands
//   halt                          stop issuing fetches
//   misalignedTrap, trapAddr      sticky misaligned-target trap and its target
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReqValid,
  output logic [31:0] imemReqAddr,
  input  logic        imemReqReady,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  output logic        instValid,
  output logic [31:0] instData,
  output logic [31:0] instPc,
  input  logic        instReady,
  input  logic        jump,
  input  logic        jumpReg,
  input  logic        assertBranch,
  input  logic [31:0] branchPc,
  input  logic [31:0] rs1Val,
  input  logic [31:0] signExtImm,
  input  logic        halt,
  output logic        misalignedTrap,
  output logic [31:0] trapAddr
);

  // ST_DROP means a request is still in flight but its response belongs to
  // a path that has since been redirected away from.
  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DROP, ST_HALTED} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        redirect;
  logic        misaligned;
  logic        reqFire;
  logic [31:0] target;

  always_comb begin
    redirect = jump | assertBranch;
    if (jump & jumpReg) begin
      target = (rs1Val + signExtImm) & ~32'h1;
    end else begin
      target = branchPc + signExtImm;
    end
    misaligned = (target[1:0] != 2'b00);
  end

  // A request only goes out when the decode buffer will have room for its
  // response, so WAIT never has to stall on a full buffer.
  assign imemReqValid = (state == ST_REQ) & ~halt & (~instValid | instReady);
  assign imemReqAddr  = pc;
  assign reqFire      = imemReqValid & imemReqReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_REQ;
      pc             <= RESET_VECTOR;
      instValid      <= 1'b0;
      instData       <= 32'h0;
      instPc         <= 32'h0;
      misalignedTrap <= 1'b0;
      trapAddr       <= 32'h0;
    end else if (state != ST_HALTED) begin
      if (instReady) begin
        instValid <= 1'b0;
      end
      if (redirect) begin
        instValid <= 1'b0;
        if (misaligned) begin
          misalignedTrap <= 1'b1;
          trapAddr       <= target;
          state          <= ST_HALTED;
        end else begin
          pc <= target;
          // Any request still outstanding after this edge is stale.
          if (state == ST_REQ) begin
            state <= reqFire ? ST_DROP : ST_REQ;
          end else begin
            state <= imemRespValid ? ST_REQ : ST_DROP;
          end
        end
      end else begin
        case (state)
          ST_REQ: begin
            if (reqFire) begin
              state <= ST_WAIT;
            end else if (halt) begin
              state <= ST_HALTED;
            end
          end
          ST_WAIT: begin
            if (imemRespValid) begin
              instData  <= imemRespData;
              instPc    <= pc;
              instValid <= 1'b1;
              pc        <= pc + 32'd4;
              state     <= ST_REQ;
            end
          end
          ST_DROP: begin
            if (imemRespValid) begin
              state <= ST_REQ;
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized and directed check of pc_sequencer against a transaction-level model
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        instValid;
  logic [31:0] instData;
  logic [31:0] instPc;
  logic        instReady;
  logic        jump;
  logic        jumpReg;
  logic        assertBranch;
  logic [31:0] branchPc;
  logic [31:0] rs1Val;
  logic [31:0] signExtImm;
  logic        halt;
  logic        misalignedTrap;
  logic [31:0] trapAddr;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst),
    .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr), .imemReqReady(imemReqReady),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .instValid(instValid), .instData(instData), .instPc(instPc), .instReady(instReady),
    .jump(jump), .jumpReg(jumpReg), .assertBranch(assertBranch),
    .branchPc(branchPc), .rs1Val(rs1Val), .signExtImm(signExtImm),
    .halt(halt), .misalignedTrap(misalignedTrap), .trapAddr(trapAddr)
  );

  int nTests = 0;
  int nFail  = 0;

  // Transaction-level model: is a fetch in flight, and does its answer still matter.
  logic [31:0] mPc;
  logic        mHalted, mBusy, mStale;
  logic        mBufValid;
  logic [31:0] mBufData, mBufPc;
  logic        mTrap;
  logic [31:0] mTrapAddr;

  // Memory environment: one pending response after a latency of memLat cycles (0 = random 1..3).
  logic        memPending;
  int          memWait;
  logic [31:0] memData;
  int          memLat;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    nTests++;
    nFail++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic modelReset();
    mPc = RV; mHalted = 0; mBusy = 0; mStale = 0;
    mBufValid = 0; mBufData = 0; mBufPc = 0; mTrap = 0; mTrapAddr = 0;
    memPending = 0; memWait = 0; memData = 0;
  endtask

  function automatic logic expReq();
    return !mHalted && !mBusy && !halt && (!mBufValid || instReady);
  endfunction

  task automatic modelEdge(input logic fire);
    logic        resp;
    logic [31:0] s, tgt;
    resp = mBusy && imemRespValid;
    if (rst) begin
      modelReset();
    end else if (!mHalted) begin
      if (instReady) mBufValid = 0;
      if (jump || assertBranch) begin
        if (jump && jumpReg) begin
          s   = rs1Val + signExtImm;
          tgt = s - (s % 2);
        end else begin
          tgt = branchPc + signExtImm;
        end
        mBufValid = 0;
        if (tgt % 4 != 0) begin
          mTrap = 1; mTrapAddr = tgt; mHalted = 1;
        end else begin
          mPc    = tgt;
          mBusy  = (mBusy && !resp) || fire;
          mStale = mBusy;
        end
      end else if (mBusy) begin
        if (resp) begin
          if (!mStale) begin
            mBufValid = 1; mBufData = imemRespData; mBufPc = mPc; mPc = mPc + 4;
          end
          mBusy = 0; mStale = 0;
        end
      end else if (fire) begin
        mBusy = 1; mStale = 0;
      end else if (halt) begin
        mHalted = 1;
      end
    end
    // memory side
    if (rst) begin
      memPending = 0;
    end else begin
      if (imemRespValid) memPending = 0;
      else if (memPending) memWait--;
      if (fire) begin
        memPending = 1;
        memWait    = (memLat == 0) ? $urandom_range(2, 0) : memLat - 1;
        memData    = memWord(imemReqAddr);
      end
    end
  endtask

  task automatic stepCycle();
    logic expRv, fire;
    imemRespValid = memPending && (memWait == 0);
    imemRespData  = imemRespValid ? memData : $urandom;
    #1;
    expRv = expReq();
    check("reqValid", {31'b0, imemReqValid}, {31'b0, expRv});
    if (expRv) check("reqAddr", imemReqAddr, mPc);
    fire = expRv && imemReqReady;
    @(posedge clk);
    modelEdge(fire);
    #1;
    check("instValid", {31'b0, instValid}, {31'b0, mBufValid});
    check("instData", instData, mBufData);
    check("instPc", instPc, mBufPc);
    check("trap", {31'b0, misalignedTrap}, {31'b0, mTrap});
    check("trapAddr", trapAddr, mTrapAddr);
  endtask

  task automatic idleInputs();
    rst = 0; imemReqReady = 1; instReady = 1; jump = 0; jumpReg = 0; assertBranch = 0;
    branchPc = 0; rs1Val = 0; signExtImm = 0; halt = 0;
  endtask

  task automatic doReset();
    rst = 1;
    stepCycle();
    rst = 0;
  endtask

  initial begin
    int bound;
    int haltedCycles;
    idleInputs();
    rst = 1; imemRespValid = 0; imemRespData = 0; memLat = 1;
    modelReset();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;

    // 1. reset and sequential fetch with zero-wait memory
    check("rst_addr", imemReqAddr, RV);
    check("rst_instValid", {31'b0, instValid}, 32'd0);
    for (int i = 0; i < 2; i++) stepCycle();
    check("seq_pc0", instPc, 32'h100);
    for (int i = 0; i < 2; i++) stepCycle();
    check("seq_pc1", instPc, 32'h104);
    for (int i = 0; i < 2; i++) stepCycle();
    check("seq_pc2", instPc, 32'h108);

    // 2. decode backpressure holds the buffer and blocks fetch
    instReady = 0;
    for (int i = 0; i < 4; i++) stepCycle();
    check("bp_hold", instData, memWord(32'h108));
    instReady = 1;
    #1; check("bp_release", {31'b0, imemReqValid}, 32'd1);
    stepCycle();

    // 3. branch while waiting on a slow response
    memLat = 3;
    bound = 0;
    while (!(mBusy && !mStale) && bound < 20) begin stepCycle(); bound++; end
    if (bound == 20) timeoutFail("wait_busy");
    assertBranch = 1; branchPc = 32'h200; signExtImm = 32'h40;
    stepCycle();
    assertBranch = 0;
    bound = 0;
    while (!expReq() && bound < 20) begin
      stepCycle();
      check("drop_noinst", {31'b0, instValid}, 32'd0);
      bound++;
    end
    if (bound == 20) timeoutFail("drop_resume");
    #1; check("drop_target", imemReqAddr, 32'h240);

    // 4. register-relative jump clears bit 0
    memLat = 1;
    jump = 1; jumpReg = 1; rs1Val = 32'h301; signExtImm = 0;
    stepCycle();
    jump = 0; jumpReg = 0;
    bound = 0;
    while (!expReq() && bound < 20) begin stepCycle(); bound++; end
    if (bound == 20) timeoutFail("jalr_resume");
    #1; check("jalr_target", imemReqAddr, 32'h300);

    // 5. misaligned branch traps and halts until reset
    assertBranch = 1; branchPc = 32'h10; signExtImm = 32'h2;
    stepCycle();
    assertBranch = 0;
    check("mis_trap", {31'b0, misalignedTrap}, 32'd1);
    check("mis_addr", trapAddr, 32'h12);
    for (int i = 0; i < 3; i++) stepCycle();
    doReset();
    check("mis_clear", {31'b0, misalignedTrap}, 32'd0);
    #1; check("mis_restart", imemReqAddr, RV);

    // 6a. halt in REQ
    halt = 1;
    stepCycle();
    halt = 0;
    for (int i = 0; i < 3; i++) stepCycle();
    #1; check("halt_noreq", {31'b0, imemReqValid}, 32'd0);
    doReset();

    // 6b. redirect together with the response in WAIT
    memLat = 2;
    bound = 0;
    while (!(mBusy && !mStale && memPending && memWait == 0) && bound < 20) begin stepCycle(); bound++; end
    if (bound == 20) timeoutFail("wait_resp");
    assertBranch = 1; branchPc = 32'h3F0; signExtImm = 32'h10;
    stepCycle();
    assertBranch = 0;
    check("simul_drop", {31'b0, instValid}, 32'd0);
    #1; check("simul_req", {31'b0, imemReqValid}, 32'd1);
    check("simul_addr", imemReqAddr, 32'h400);

    // randomized traffic
    memLat = 0;
    haltedCycles = 0;
    for (int n = 0; n < 4000; n++) begin
      int r;
      idleInputs();
      imemReqReady = ($urandom % 4) != 0;
      instReady    = ($urandom % 3) != 0;
      halt         = ($urandom % 40) == 0;
      r = $urandom % 16;
      jump         = (r < 2);
      assertBranch = (r == 1) || (r == 2) || (r == 3);
      jumpReg      = $urandom % 2;
      branchPc     = ($urandom % 4096) * 4;
      if ($urandom % 20 == 0) signExtImm = $urandom % 4;
      else if ($urandom % 2 == 0) signExtImm = ($urandom % 256) * 4;
      else signExtImm = -(($urandom % 256) * 4);
      rs1Val = (($urandom % 8) == 0) ? $urandom : (($urandom % 4096) * 4 + ($urandom % 2));
      haltedCycles = mHalted ? haltedCycles + 1 : 0;
      rst = ($urandom % 300 == 0) || (haltedCycles > 6);
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
